// File: rtl/ddr_pkg.sv
// ddr_pkg: command encoding, burst states and burst helpers shared by the DDR bank array
package ddr_pkg;
    typedef enum logic [2:0] {NOP = 3'd0, ACT = 3'd1, PRE = 3'd2, RD = 3'd3, WR = 3'd4, BST = 3'd5} cmd_e;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} burst_e;
    // burst length from the mode field, 0 marks an illegal setting
    function automatic logic [4:0] bl_decode(input logic [2:0] mode_bl, input int max_bl);
        return mode_bl == 3'd1 ? 5'd2 : mode_bl == 3'd2 ? 5'd4 : mode_bl == 3'd3 ? 5'd8 :
               (mode_bl == 3'd4 && max_bl == 16) ? 5'd16 : 5'd0;
    endfunction
    // low column nibble of beat i; bits above log2(bl) pass through unchanged
    function automatic logic [3:0] burst_col(input logic [3:0] col, input logic [3:0] i, input logic [4:0] bl, input logic bt);
        logic [3:0] m;
        m = 4'(bl - 5'd1);
        return (col & ~m) | ((bt ? (col ^ i) : (col + i)) & m);
    endfunction
endpackage

// File: rtl/ddr_burst_addr_gen.sv
// ddr_burst_addr_gen: beat counter and column sequencer for the active burst
module ddr_burst_addr_gen
    import ddr_pkg::*;
#(
    parameter int COL_WIDTH = 10
) (
    input  logic                 clk2x,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 skip,
    input  logic [COL_WIDTH-1:0] start_col,
    input  logic [4:0]           start_bl,
    input  logic                 start_bt,
    input  logic                 advance,
    output logic [COL_WIDTH-1:0] col,
    output logic                 last
);
    logic [COL_WIDTH-1:0] col_q;
    logic [4:0] bl_q;
    logic [3:0] cnt;
    logic bt_q;
    // latch a new burst (skipping beat 0 when it was already issued) or step one beat
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            bl_q <= '0;
            bt_q <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            col_q <= start_col;
            bl_q <= start_bl;
            bt_q <= start_bt;
            cnt <= skip ? 4'd1 : 4'd0;
        end else if (advance) begin
            cnt <= cnt + 4'd1;
        end
    end
    assign col = {col_q[COL_WIDTH-1:4], burst_col(col_q[3:0], cnt, bl_q, bt_q)};
    assign last = {1'b0, cnt} == bl_q - 5'd1;
endmodule

// File: rtl/ddr_bank_array.sv
// ddr_bank_array: multi-bank DDR storage with open-row tracking, burst engine and latency-matched read return
module ddr_bank_array
    import ddr_pkg::*;
#(
    parameter int ROW_WIDTH = 14,
    parameter int COL_WIDTH = 10,
    parameter int BANKS = 4,
    parameter int DW = 16,
    parameter int MAX_BL = 8,
    parameter int RD_LAT = 2,
    localparam int BA_W = $clog2(BANKS),
    localparam int MW = DW / 8
) (
    input  logic                 clk2x,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    input  logic [BA_W-1:0]      cmd_ba,
    input  logic [ROW_WIDTH-1:0] cmd_addr,
    input  logic [2:0]           mode_bl,
    input  logic                 mode_bt,
    input  logic                 wr_valid,
    input  logic [DW-1:0]        wr_data,
    input  logic [MW-1:0]        wr_mask,
    output logic                 wr_ready,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [BANKS-1:0]     row_open,
    output logic                 busy,
    output logic                 cmd_err
);
`ifdef SYNTHESIS
    localparam int RA = 4;
    localparam int CA = 4;
`else
    localparam int RA = ROW_WIDTH;
    localparam int CA = COL_WIDTH;
`endif
    localparam int AW = BA_W + RA + CA;
    burst_e state, state_nx;
    cmd_e op;
    logic [ROW_WIDTH-1:0] rows [BANKS];
    logic [BA_W-1:0] bank_q;
    logic [ROW_WIDTH-1:0] brow_q;
    logic [4:0] bl_new;
    logic is_act, is_pre, is_rd, is_wr, is_bst, is_rw, rw_ok, bank_busy, err;
    logic last, rd_issue, wr_fire, advance;
    logic [COL_WIDTH-1:0] gcol;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_word;
    logic [RD_LAT-1:0] pv;
    logic [DW-1:0] pd [RD_LAT];

    assign op = cmd_e'(cmd);
    assign is_act = cmd_valid && op == ACT;
    assign is_pre = cmd_valid && op == PRE;
    assign is_rd = cmd_valid && op == RD;
    assign is_wr = cmd_valid && op == WR;
    assign is_bst = cmd_valid && op == BST;
    assign is_rw = is_rd || is_wr;
    assign bl_new = bl_decode(mode_bl, MAX_BL);
    assign bank_busy = state != IDLE && bank_q == cmd_ba;
    assign rw_ok = is_rw && row_open[cmd_ba] && bl_new != 5'd0;
    assign err = (is_act && row_open[cmd_ba]) || (is_pre && bank_busy) || (is_rw && !rw_ok);

    // a legal RD/WR always replaces the running burst; BST or the final beat return to IDLE
    always_comb begin
        rd_issue = (rw_ok && is_rd) || (state == READ && !rw_ok);
        wr_fire = state == WRITE && wr_valid;
        advance = (state == READ && !rw_ok) || wr_fire;
        state_nx = rw_ok ? (is_rd ? READ : WRITE) :
                   (is_bst || (state == READ && last) || (wr_fire && last)) ? IDLE : state;
    end

    ddr_burst_addr_gen #(.COL_WIDTH(COL_WIDTH)) u_gen (
        .clk2x(clk2x),
        .rst_n(rst_n),
        .start(rw_ok),
        .skip(is_rd),
        .start_col(cmd_addr[COL_WIDTH-1:0]),
        .start_bl(bl_new),
        .start_bt(mode_bt),
        .advance(advance),
        .col(gcol),
        .last(last)
    );

    // beat 0 of a read is addressed straight from the command so it issues in the acceptance cycle
    assign rd_idx = (rw_ok && is_rd) ? {cmd_ba, rows[cmd_ba][RA-1:0], cmd_addr[CA-1:0]}
                                     : {bank_q, brow_q[RA-1:0], gcol[CA-1:0]};
    assign wr_idx = {bank_q, brow_q[RA-1:0], gcol[CA-1:0]};
    assign rd_word = mem[rd_idx];

    // burst state, open rows, latched burst bank/row and the error pulse
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row_open <= '0;
            bank_q <= '0;
            brow_q <= '0;
            cmd_err <= 1'b0;
            for (int b = 0; b < BANKS; b++) rows[b] <= '0;
        end else begin
            state <= state_nx;
            cmd_err <= err;
            if (rw_ok) begin
                bank_q <= cmd_ba;
                brow_q <= rows[cmd_ba];
            end
            if (is_act && !row_open[cmd_ba]) begin
                row_open[cmd_ba] <= 1'b1;
                rows[cmd_ba] <= cmd_addr;
            end
            if (is_pre && !bank_busy) row_open[cmd_ba] <= 1'b0;
        end
    end

    // storage keeps its contents across reset; masked bytes are left untouched
    always_ff @(posedge clk2x) begin
        if (wr_fire)
            for (int k = 0; k < MW; k++)
                if (!wr_mask[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end

    // read return pipeline; data stages only move with valid so rd_data holds between beats
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < RD_LAT; k++) pd[k] <= '0;
        end else begin
            pv[0] <= rd_issue;
            if (rd_issue) pd[0] <= rd_word;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) pd[k] <= pd[k-1];
            end
        end
    end

    assign rd_valid = pv[RD_LAT-1];
    assign rd_data = pd[RD_LAT-1];
    assign busy = state != IDLE;
    assign wr_ready = state == WRITE;
endmodule

// File: tb/tb_ddr_bank_array.sv
// tb_ddr_bank_array: directed and random stimulus against a transaction-level model of the bank array
module tb_ddr_bank_array;
    localparam int NB = 4;
    localparam int MBL = 8;
    localparam int LAT = 2;
    logic clk2x = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, mode_bt = 1'b0, wr_valid = 1'b0;
    logic [2:0] cmd = '0, mode_bl = 3'd2;
    logic [1:0] cmd_ba = '0, wr_mask = '0;
    logic [13:0] cmd_addr = '0;
    logic [15:0] wr_data = '0;
    logic wr_ready, rd_valid, busy, cmd_err;
    logic [15:0] rd_data;
    logic [3:0] row_open;

    ddr_bank_array #(.ROW_WIDTH(14), .COL_WIDTH(10), .BANKS(NB), .DW(16), .MAX_BL(MBL), .RD_LAT(LAT)) dut (
        .clk2x(clk2x), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba),
        .cmd_addr(cmd_addr), .mode_bl(mode_bl), .mode_bt(mode_bt), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_ready(wr_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .row_open(row_open), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk2x = ~clk2x;

    typedef struct {int due; bit [15:0] d;} beat_t;
    bit [15:0] mem [int];
    bit mopen [NB];
    int mrowv [NB];
    int mst, mb, mr, mc, mbl, mbt, mi, ncyc;
    beat_t pq [$];
    bit [15:0] mlast;
    bit merr;
    int n_chk = 0, n_pass = 0, rv_cnt = 0;
    bit [15:0] rv_first, rv_last;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int key(input int b, input int r, input int c);
        return (b << 24) | (r << 10) | c;
    endfunction

    function automatic bit [15:0] rdm(input int k);
        return mem.exists(k) ? mem[k] : 16'h0;
    endfunction

    function automatic int bl_of(input int m);
        return (m >= 1 && m <= 3) ? (1 << m) : (m == 4 && MBL == 16) ? 16 : 0;
    endfunction

    function automatic int bcol(input int col, input int bl, input int bt, input int i);
        int lo;
        lo = col % bl;
        return col - lo + (bt != 0 ? (lo ^ i) : ((lo + i) % bl));
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) mopen[b] = 0;
        mst = 0;
        pq.delete();
        mlast = 0;
        merr = 0;
    endtask

    task automatic cycle();
        int c, bl, k, ro;
        bit rw, legal, hit, issue, ev;
        bit [15:0] rdv, w;
        @(posedge clk2x);
        c = cmd_valid ? int'(cmd) : 0;
        bl = bl_of(mode_bl);
        rw = c == 3 || c == 4;
        legal = rw && mopen[cmd_ba] && bl != 0;
        hit = mst != 0 && mb == cmd_ba;
        merr = (c == 1 && mopen[cmd_ba]) || (c == 2 && hit) || (rw && !legal);
        issue = 0;
        rdv = 0;
        if (legal && c == 3) begin
            issue = 1;
            rdv = rdm(key(cmd_ba, mrowv[cmd_ba], cmd_addr % 1024));
        end else if (mst == 1 && !legal) begin
            issue = 1;
            rdv = rdm(key(mb, mr, bcol(mc, mbl, mbt, mi)));
            mi++;
            if (mi == mbl) mst = 0;
        end
        if (mst == 2 && wr_valid) begin
            k = key(mb, mr, bcol(mc, mbl, mbt, mi));
            w = rdm(k);
            if (!wr_mask[0]) w[7:0] = wr_data[7:0];
            if (!wr_mask[1]) w[15:8] = wr_data[15:8];
            mem[k] = w;
            mi++;
            if (mi == mbl) mst = 0;
        end
        if (legal) begin
            mst = c == 3 ? 1 : 2;
            mb = cmd_ba;
            mr = mrowv[cmd_ba];
            mc = cmd_addr % 1024;
            mbl = bl;
            mbt = mode_bt;
            mi = c == 3 ? 1 : 0;
        end else if (c == 5) mst = 0;
        if (c == 1 && !mopen[cmd_ba]) begin
            mopen[cmd_ba] = 1;
            mrowv[cmd_ba] = cmd_addr;
        end
        if (c == 2 && !hit) mopen[cmd_ba] = 0;
        if (issue) pq.push_back('{ncyc + LAT - 1, rdv});
        ev = pq.size() > 0 && pq[0].due == ncyc;
        if (ev) begin
            mlast = pq[0].d;
            void'(pq.pop_front());
        end
        ncyc++;
        ro = 0;
        for (int b = 0; b < NB; b++) ro |= int'(mopen[b]) << b;
        #1;
        chk("rd_valid", rd_valid, ev);
        chk("rd_data", rd_data, mlast);
        chk("row_open", row_open, ro);
        chk("busy", busy, mst != 0);
        chk("wr_ready", wr_ready, mst == 2);
        chk("cmd_err", cmd_err, merr);
        if (rd_valid) begin
            if (rv_cnt == 0) rv_first = rd_data;
            rv_last = rd_data;
            rv_cnt++;
        end
    endtask

    task automatic op(input int c, input int ba, input int addr);
        cmd_valid = 1'b1;
        cmd = 3'(c);
        cmd_ba = 2'(ba);
        cmd_addr = 14'(addr);
        cycle();
        cmd_valid = 1'b0;
        cmd = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        ncyc = 0;
        repeat (3) @(posedge clk2x);
        #1;
        chk("rst_row_open", row_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        @(negedge clk2x);
        rst_n = 1'b1;
        idle(2);
        // 1: sequential BL4 write then read from a different start column
        op(1, 1, 'h12);
        mode_bl = 3'd2;
        mode_bt = 1'b0;
        op(4, 1, 6);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1;
            wr_data = 16'('hA0 + k);
            cycle();
        end
        wr_valid = 1'b0;
        rv_cnt = 0;
        op(3, 1, 4);
        idle(6);
        chk("t1_beats", rv_cnt, 4);
        chk("t1_first", rv_first, 'hA2);
        chk("t1_last", rv_last, 'hA1);
        // 2: interleaved BL8 read
        mode_bl = 3'd3;
        mode_bt = 1'b1;
        rv_cnt = 0;
        op(3, 1, 5);
        idle(10);
        chk("t2_beats", rv_cnt, 8);
        chk("t2_first", rv_first, 'hA3);
        // 3: byte masked overwrite
        mode_bl = 3'd1;
        mode_bt = 1'b0;
        op(4, 1, 3);
        wr_valid = 1'b1;
        wr_data = 16'hFFFF;
        idle(2);
        wr_valid = 1'b0;
        op(4, 1, 3);
        wr_valid = 1'b1;
        wr_data = 16'h1234;
        wr_mask = 2'b10;
        cycle();
        wr_valid = 1'b0;
        wr_mask = 2'b00;
        op(5, 0, 0);
        rv_cnt = 0;
        op(3, 1, 3);
        idle(4);
        chk("t3_masked", rv_first, 'hFF34);
        // 4: read interrupted by read, then read terminated by BST
        mode_bl = 3'd3;
        rv_cnt = 0;
        op(3, 1, 0);
        idle(2);
        op(3, 1, 8);
        idle(12);
        chk("t4_interrupt", rv_cnt, 11);
        rv_cnt = 0;
        op(3, 1, 0);
        op(5, 0, 0);
        idle(6);
        chk("t4_bst", rv_cnt, 2);
        // 5: illegal commands
        op(3, 2, 0);
        chk("t5_rd_closed", cmd_err, 1);
        op(1, 1, 'h40);
        chk("t5_act_open", cmd_err, 1);
        op(3, 1, 0);
        op(2, 1, 0);
        chk("t5_pre_busy", cmd_err, 1);
        chk("t5_still_open", row_open[1], 1);
        idle(10);
        mode_bl = 3'd0;
        op(3, 1, 0);
        chk("t5_bad_bl", cmd_err, 1);
        idle(2);
        // 6: reset in the middle of a write burst
        mode_bl = 3'd2;
        op(4, 1, 'h10);
        wr_valid = 1'b1;
        wr_data = 16'h1111;
        cycle();
        wr_data = 16'h2222;
        cycle();
        wr_data = 16'h3333;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_ready", wr_ready, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_row_open", row_open, 0);
        model_reset();
        wr_valid = 1'b0;
        repeat (2) @(posedge clk2x);
        @(negedge clk2x);
        rst_n = 1'b1;
        op(1, 1, 'h12);
        rv_cnt = 0;
        op(3, 1, 'h10);
        idle(6);
        chk("t6_beats", rv_cnt, 4);
        chk("t6_kept", rv_first, 'h1111);
        // random traffic
        for (int i = 0; i < 2500; i++) begin
            cmd_valid = $urandom_range(0, 2) == 0;
            cmd = 3'($urandom_range(0, 7));
            cmd_ba = 2'($urandom_range(0, 3));
            cmd_addr = 14'($urandom_range(0, 31));
            mode_bl = 3'($urandom_range(0, 4));
            mode_bt = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            wr_data = 16'($urandom);
            wr_mask = 2'($urandom_range(0, 3));
            cycle();
        end
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        op(5, 0, 0);
        idle(8);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
